am_search_ctrl: RTL and testbench
=================================

AM_SEARCH_CTRL -- requirements
Module: am_search_ctrl

Interface
REQ-001 Parameter: NUM_CLASS, default 16, number of class hypervectors held in associative memory (>= 1).
REQ-002 Parameter: CW, default $clog2(NUM_CLASS) (1 when NUM_CLASS = 1), class index width.
REQ-003 Width SW = $clog2(`DIM)+1 for all distances.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 q_valid  input  1  query hypervector offered.
REQ-007 q_ready  output  1  controller accepts query (high only in IDLE).
REQ-008 query  input  `DIM  query hypervector, sampled on q_valid & q_ready.
REQ-009 mem_rd_en  output  1  associative-memory read strobe.
REQ-010 mem_addr  output  CW  class index being read.
REQ-011 mem_data  input  `DIM  class hypervector, valid exactly 1 cycle after mem_rd_en.
REQ-012 sim_a  output  `DIM  registered query, to similarity unit operand a.
REQ-013 sim_b  output  `DIM  combinational pass-through of mem_data, to operand b.
REQ-014 sim_in  input  SW  Hamming distance from similarity unit, registered, valid 1 cycle after operands.
REQ-015 res_valid  output  1  search result available.
REQ-016 res_ready  input  1  consumer accepts result.
REQ-017 res_class  output  CW  index of nearest class.
REQ-018 res_dist  output  SW  distance of nearest class.

Function
REQ-019 States: IDLE, SCAN, DRAIN, DONE; encoding free.
REQ-020 IDLE: q_ready=1; on q_valid, latch query into sim_a register, clear address counter, go SCAN.
REQ-021 SCAN: mem_rd_en=1, mem_addr = counter, counter increments each cycle; after issuing address NUM_CLASS-1, go DRAIN.
REQ-022 Result for address k arrives on sim_in exactly 2 cycles after mem_rd_en for k; a 2-stage valid/index shift pipeline tracks it.
REQ-023 DRAIN: mem_rd_en=0; stay until pipeline reports last index (NUM_CLASS-1) compared, then go DONE.
REQ-024 Compare: first returned result (index 0) unconditionally loads best; later results replace best only when sim_in < best_dist (strict); ties keep lower index.
REQ-025 DONE: res_valid=1, res_class/res_dist stable; on res_ready go IDLE in same edge.
REQ-026 Query-to-res_valid latency = NUM_CLASS + 2 cycles after the accepting edge.
REQ-027 q_valid ignored outside IDLE; sim_a stays constant for the whole search.
REQ-028 NUM_CLASS = 1: SCAN lasts 1 cycle, result = index 0 with its distance.
REQ-029 Counter never wraps: mem_addr held at NUM_CLASS-1 after last issue; no read beyond NUM_CLASS-1.
REQ-030 res_ready with res_valid low has no effect.

Reset
REQ-031 On rst_n low, asynchronously: state=IDLE, q_ready=1, mem_rd_en=0, mem_addr=0, res_valid=0, res_class=0, res_dist=0, pipeline valids cleared, sim_a register=0.
REQ-032 Reset asserted mid-SCAN/DRAIN/DONE aborts search; no partial result is ever presented after release.

Verification
REQ-033 NUM_CLASS=4, distances {7,3,9,5} -> res_class=1, res_dist=3, res_valid 6 cycles after query accepted.
REQ-034 Tie: distances {4,2,2,8} -> res_class=1, res_dist=2.
REQ-035 Backpressure: hold res_ready=0 for 10 cycles -> res_valid, res_class, res_dist stable, q_ready=0; res_ready=1 -> IDLE next cycle, q_ready=1.
REQ-036 Query equal to class 2 ({x,x,0,x}) -> res_class=2, res_dist=0; all-ones complement class -> distance `DIM never selected over smaller.
REQ-037 rst_n pulsed low during SCAN at address 2 -> outputs at reset values immediately; next query runs full NUM_CLASS scan and gives correct result.
REQ-038 Back-to-back queries with res_ready tied high -> each result correct, mem_addr sequence 0..NUM_CLASS-1 per query, no address past NUM_CLASS-1.

Source files
------------

// File: rtl/am_search_ctrl.sv
// Associative-memory search controller: streams every class hypervector past the
// similarity unit and keeps the nearest (smallest Hamming distance) class.
`ifndef DIM
`define DIM 64
`endif

module am_search_ctrl #(
  parameter int  NUM_CLASS = 16,
  parameter int  CW        = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1,
  localparam int SW        = $clog2(`DIM) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            q_valid,
  output logic            q_ready,
  input  logic [`DIM-1:0] query,
  output logic            mem_rd_en,
  output logic [CW-1:0]   mem_addr,
  input  logic [`DIM-1:0] mem_data,
  output logic [`DIM-1:0] sim_a,
  output logic [`DIM-1:0] sim_b,
  input  logic [SW-1:0]   sim_in,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [CW-1:0]   res_class,
  output logic [SW-1:0]   res_dist
);

  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CLASS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [`DIM-1:0] query_q, query_d;
  logic [CW-1:0]   best_cls_q, best_cls_d;
  logic [SW-1:0]   best_dist_q, best_dist_d;
  logic            v1_q, v2_q;
  logic [CW-1:0]   idx1_q, idx2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    query_d     = query_q;
    best_cls_d  = best_cls_q;
    best_dist_d = best_dist_q;
    q_ready     = 1'b0;
    mem_rd_en   = 1'b0;
    res_valid   = 1'b0;

    // Index 0 seeds the running minimum; strict compare keeps the lower index on ties.
    if (v2_q && ((idx2_q == '0) || (sim_in < best_dist_q))) begin
      best_cls_d  = idx2_q;
      best_dist_d = sim_in;
    end

    case (state_q)
      IDLE: begin
        q_ready = 1'b1;
        if (q_valid) begin
          query_d = query;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        mem_rd_en = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (v2_q && (idx2_q == LAST_IDX)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      query_q     <= '0;
      best_cls_q  <= '0;
      best_dist_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      query_q     <= query_d;
      best_cls_q  <= best_cls_d;
      best_dist_q <= best_dist_d;
    end
  end

  // Two stages match memory read latency plus the similarity unit's output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      idx1_q <= '0;
      idx2_q <= '0;
    end else begin
      v1_q   <= mem_rd_en;
      v2_q   <= v1_q;
      idx1_q <= cnt_q;
      idx2_q <= idx1_q;
    end
  end

  assign mem_addr  = cnt_q;
  assign sim_a     = query_q;
  assign sim_b     = mem_data;
  assign res_class = best_cls_q;
  assign res_dist  = best_dist_q;

endmodule

// File: tb/tb_am_search_ctrl.sv
// Directed bench for am_search_ctrl with a registered-read memory model and a
// registered Hamming-distance model; expected results are hand-computed constants.
`ifndef DIM
`define DIM 64
`endif

module tb_am_search_ctrl;
  localparam int NC   = 4;
  localparam int CW   = 2;
  localparam int SW   = $clog2(`DIM) + 1;
  localparam int CHKW = (`DIM > 32) ? `DIM : 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            q_valid = 1'b0;
  logic            q_ready;
  logic [`DIM-1:0] query = '0;
  logic            mem_rd_en;
  logic [CW-1:0]   mem_addr;
  logic [`DIM-1:0] mem_data = '0;
  logic [`DIM-1:0] sim_a, sim_b;
  logic [SW-1:0]   sim_in = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [CW-1:0]   res_class;
  logic [SW-1:0]   res_dist;

  logic [`DIM-1:0] mem [NC];
  int              addr_log [$];
  int              n_cmp = 0;
  int              n_bad = 0;

  am_search_ctrl #(.NUM_CLASS(NC), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .q_valid(q_valid), .q_ready(q_ready), .query(query),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .sim_a(sim_a), .sim_b(sim_b), .sim_in(sim_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class), .res_dist(res_dist)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_data <= mem[mem_addr];
      addr_log.push_back(int'(mem_addr));
    end
    sim_in <= SW'($countones(sim_a ^ sim_b));
  end

  task automatic chk(input string tag, input logic [CHKW-1:0] got, input logic [CHKW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [`DIM-1:0] ones(input int n);
    logic [`DIM-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic set_dists(input int d0, input int d1, input int d2, input int d3);
    mem[0] = ones(d0);
    mem[1] = ones(d1);
    mem[2] = ones(d2);
    mem[3] = ones(d3);
  endtask

  // Offers one query, waits for the result and checks latency, result and read sequence.
  task automatic run_query(input string tag, input logic [`DIM-1:0] q,
                           input int exp_cls, input int exp_dist);
    int lat;
    int waited;
    waited = 0;
    @(negedge clk);
    while (!q_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    chk({tag, "_qready"}, CHKW'(q_ready), CHKW'(1));
    addr_log.delete();
    q_valid = 1'b1;
    query   = q;
    @(posedge clk);
    #1 q_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, CHKW'(lat), CHKW'(NC + 2));
    chk({tag, "_class"}, CHKW'(res_class), CHKW'(exp_cls));
    chk({tag, "_dist"}, CHKW'(res_dist), CHKW'(exp_dist));
    chk({tag, "_sim_a"}, CHKW'(sim_a), CHKW'(q));
    chk({tag, "_nreads"}, CHKW'(addr_log.size()), CHKW'(NC));
    for (int k = 0; k < addr_log.size(); k++)
      chk({tag, "_addr"}, CHKW'(addr_log[k]), CHKW'(k));
    $display("query %s: class=%0d dist=%0d latency=%0d", tag, res_class, res_dist, lat);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_rel_valid"}, CHKW'(res_valid), CHKW'(0));
    chk({tag, "_rel_qready"}, CHKW'(q_ready), CHKW'(1));
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    logic [`DIM-1:0] qv;
    logic [`DIM-1:0] held_a;
    int waited;

    set_dists(7, 3, 9, 5);
    #12;
    chk("rst_qready", CHKW'(q_ready), CHKW'(1));
    chk("rst_rd_en", CHKW'(mem_rd_en), CHKW'(0));
    chk("rst_addr", CHKW'(mem_addr), CHKW'(0));
    chk("rst_valid", CHKW'(res_valid), CHKW'(0));
    chk("rst_class", CHKW'(res_class), CHKW'(0));
    chk("rst_dist", CHKW'(res_dist), CHKW'(0));
    chk("rst_sim_a", CHKW'(sim_a), CHKW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic minimum search
    run_query("basic", '0, 1, 3);
    release_result("basic");

    // Tie keeps the lower index
    set_dists(4, 2, 2, 8);
    run_query("tie", '0, 1, 2);
    release_result("tie");

    // Exact match at class 2, complement at class 0
    qv = `DIM'(64'hA5C3_1E96_0FF0_5A3C);
    mem[0] = ~qv;
    mem[1] = qv ^ `DIM'(3);
    mem[2] = qv;
    mem[3] = qv ^ `DIM'(1);
    run_query("exact", qv, 2, 0);
    release_result("exact");

    // Complement (distance DIM) at index 0 must lose to anything smaller
    mem[0] = ~qv;
    mem[1] = qv ^ ones(5);
    mem[2] = qv ^ ones(6);
    mem[3] = qv ^ ones(7);
    run_query("compl", qv, 1, 5);

    // Backpressure: result held, competing query ignored, sim_a stable
    held_a = sim_a;
    @(negedge clk);
    q_valid = 1'b1;
    query   = ~qv;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_valid", CHKW'(res_valid), CHKW'(1));
    chk("bp_class", CHKW'(res_class), CHKW'(1));
    chk("bp_dist", CHKW'(res_dist), CHKW'(5));
    chk("bp_qready", CHKW'(q_ready), CHKW'(0));
    chk("bp_sim_a", CHKW'(sim_a), CHKW'(held_a));
    @(negedge clk);
    q_valid = 1'b0;
    release_result("bp");

    // Reset pulsed mid-scan at address 2
    set_dists(7, 3, 9, 5);
    @(negedge clk);
    q_valid = 1'b1;
    query   = '0;
    @(posedge clk);
    #1 q_valid = 1'b0;
    waited = 0;
    while (!(mem_rd_en && mem_addr == 2'd2) && waited < 20) begin
      @(posedge clk);
      #1 waited++;
    end
    chk("mid_reached_a2", CHKW'(mem_addr), CHKW'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_qready", CHKW'(q_ready), CHKW'(1));
    chk("mid_rd_en", CHKW'(mem_rd_en), CHKW'(0));
    chk("mid_addr", CHKW'(mem_addr), CHKW'(0));
    chk("mid_valid", CHKW'(res_valid), CHKW'(0));
    chk("mid_dist", CHKW'(res_dist), CHKW'(0));
    chk("mid_sim_a", CHKW'(sim_a), CHKW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("mid_no_partial", CHKW'(res_valid), CHKW'(0));
    run_query("after_rst", '0, 1, 3);
    release_result("after_rst");

    // Back-to-back queries with res_ready tied high
    res_ready = 1'b1;
    run_query("b2b0", `DIM'(9'h007), 1, 0);
    run_query("b2b1", `DIM'(9'h1FF), 2, 0);
    run_query("b2b2", `DIM'(9'h01F), 3, 0);
    run_query("b2b3", `DIM'(9'h000), 1, 3);
    @(posedge clk);
    #1;
    chk("b2b_end_valid", CHKW'(res_valid), CHKW'(0));
    chk("b2b_end_addr", CHKW'(mem_addr), CHKW'(3));
    res_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
